vecmat_pack: RTL
================

// Module: vecmat_pack
// PURPOSE
//  Stream-to-vector packer: the producer side of the vector reduction tree's
//  wide input. Accepts DATA_WIDTH elements serially with valid/ready and
//  assembles VECT_DEPTH of them into one ARRAYSIZE-bit vector.
//  Emits the vector on a valid/ready output whose lane order matches the
//  tree's mulout bus: element k sits at [16*k +: 16].
// PARAMETERS
//  DATA_WIDTH  16    element width, bits
//  VECT_DEPTH  64    elements per vector
//  ARRAYSIZE   1024  output vector width; must equal DATA_WIDTH*VECT_DEPTH
//  CNT_W       7     count width; holds 0..VECT_DEPTH
// PORTS
//  clk        in   1          clock; all logic on rising edge
//  reset      in   1          synchronous, active-low
//  in_valid   in   1          in_data/in_last valid
//  in_ready   out  1          packer can accept an element this cycle
//  in_data    in   DATA_WIDTH element
//  in_last    in   1          final element of a short vector
//  out_valid  out  1          out_vec/out_count valid
//  out_ready  in   1          consumer accepts vector
//  out_vec    out  ARRAYSIZE  packed vector, lane k = [DATA_WIDTH*k +: DATA_WIDTH]
//  out_count  out  CNT_W      real elements in out_vec (1..VECT_DEPTH)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=FILL, idx=0, out_valid=0, out_vec=0,
//    out_count=0. in_ready=0 whenever reset==0. A partial vector is discarded.
//  - Accept = in_valid & in_ready; Emit = out_valid & out_ready.
//  - FILL state: in_ready=1.
//    - Each accept writes in_data to lane idx and increments idx.
//    - Accept with idx==VECT_DEPTH-1 or in_last=1 -> HOLD.
//    - On that transition: out_count=idx+1, out_valid=1 on the next cycle.
//  - HOLD state: in_ready=0; out_vec/out_count held stable until Emit.
//    - On Emit: buffer cleared to 0, idx=0, out_valid=0 next cycle -> FILL.
//  - Lanes at or above out_count read as zero (zero-fill for short vectors).
//  - Latency: last accept in cycle N -> out_valid=1 in cycle N+1.
//  - in_last on lane VECT_DEPTH-1: same as a normal full vector.
//  - in_last with in_valid=0: ignored.
//  - Throughput (no DBUF): one vector per VECT_DEPTH+1 cycles minimum.
//  - No arithmetic on data; elements pass through bit-exact.
// CONFIGURATION
//  VECMAT_PACK_DBUF_EN defined: two banks (ping/pong).
//   - Fill bank and hold bank swap on the completing accept.
//   - in_ready=0 only when both banks are full. Fill may proceed while the
//     other bank awaits Emit.
//   - Sustains 1 element/cycle with out_ready=1; latency unchanged.
//   - Vectors are emitted in fill order.
//   - A completing accept and an Emit in the same cycle: both are taken;
//     out_valid stays 1 with the new bank.
//  Not defined: single bank; behaviour exactly as in BEHAVIOUR.
// TESTING
//  1 Feed 1..64 back-to-back, out_ready=1
//    -> lane k == k+1, out_count=64, out_valid one cycle after 64th accept.
//  2 Full vector, out_ready=0 for 10 cycles
//    -> out_vec/out_count stable; in_ready=0 (no DBUF); single Emit on release.
//  3 Values 7,8,9,10,11 with in_last on 11
//    -> lanes 0-4 = 7..11, lanes 5-63 = 0, out_count=5.
//  4 Drive reset=0 for one cycle after 30 accepts
//    -> out_valid=0, out_vec=0; next 64 elements land at lanes 0..63.
//  5 (DBUF) 128 elements continuous, out_ready=1
//    -> in_ready never drops; two vectors, lanes 1..64 then 65..128.
//  6 (DBUF) out_ready=0, stream 130 elements
//    -> in_ready falls after the 128th accept; first Emit re-raises it next cycle.

Source files
------------

// File: rtl/vecmat_pack.sv
// vecmat_pack: packs a serial element stream into one wide vector for the reduction tree.
// Optional VECMAT_PACK_DBUF_EN selects a ping/pong bank pair so filling overlaps the consumer.
module vecmat_pack #(
  parameter int DATA_WIDTH = 16,
  parameter int VECT_DEPTH = 64,
  parameter int ARRAYSIZE  = 1024,
  parameter int CNT_W      = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ARRAYSIZE-1:0]  out_vec,
  output logic [CNT_W-1:0]      out_count
);

  localparam int IDX_W = (VECT_DEPTH > 1) ? $clog2(VECT_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECT_DEPTH - 1);

  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             emit;
  logic             last_lane;

  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign last_lane = (idx == LAST_IDX) | in_last;

`ifdef VECMAT_PACK_DBUF_EN

  // Bank wr_sel fills while bank rd_sel is presented; both pointers simply
  // alternate, so a full write bank implies both banks are full.
  logic [1:0][VECT_DEPTH-1:0][DATA_WIDTH-1:0] banks;
  logic [1:0][CNT_W-1:0]                      cnt;
  logic [1:0]                                 full;
  logic                                       wr_sel;
  logic                                       rd_sel;

  assign in_ready  = reset & ~full[wr_sel];
  assign out_valid = full[rd_sel];
  assign out_vec   = banks[rd_sel];
  assign out_count = cnt[rd_sel];

  always_ff @(posedge clk) begin
    if (!reset) begin
      banks  <= '0;
      cnt    <= '0;
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      idx    <= '0;
    end else begin
      // An emitting bank is always full and a filling bank never is, so the
      // two updates below never touch the same bank in one cycle.
      if (emit) begin
        banks[rd_sel] <= '0;
        cnt[rd_sel]   <= '0;
        full[rd_sel]  <= 1'b0;
        rd_sel        <= ~rd_sel;
      end
      if (accept) begin
        banks[wr_sel][idx] <= in_data;
        if (last_lane) begin
          full[wr_sel] <= 1'b1;
          cnt[wr_sel]  <= CNT_W'(idx) + CNT_W'(1);
          wr_sel       <= ~wr_sel;
          idx          <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

`else

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                                state;
  logic [VECT_DEPTH-1:0][DATA_WIDTH-1:0] lanes;

  assign in_ready = reset & (state == FILL);
  assign out_vec  = lanes;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FILL;
      idx       <= '0;
      // NOTE: the lane storage is reset (not left undefined) because unused
      // lanes must read as zero and a discarded partial vector must vanish.
      lanes     <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            lanes[idx] <= in_data;
            if (last_lane) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_count <= CNT_W'(idx) + CNT_W'(1);
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (emit) begin
            state     <= FILL;
            idx       <= '0;
            lanes     <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`endif

endmodule
